// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp. It carries the clear request, the two write ports and the NUM_RD read ports.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     clr_i;
   logic                     ready_o;
   logic                     we0_i;
   logic [ADDR_W-1:0]        waddr0_i;
   logic [DATA_W-1:0]        wdata0_i;
   logic                     we1_i;
   logic [ADDR_W-1:0]        waddr1_i;
   logic [DATA_W-1:0]        wdata1_i;
   logic [NUM_RD-1:0]        re_i;
   logic [NUM_RD*ADDR_W-1:0] raddr_i;
   logic [NUM_RD*DATA_W-1:0] rdata_o;
   logic                     wcol_o;

   // Handshake: a write is taken on a rising edge only when ready_o=1, clr_i=0 and its we is 1.
   // Any write offered while ready_o=0 is dropped. It is not held or retried.
   modport slave (
      input  clr_i, we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i, re_i, raddr_i,
      output ready_o, rdata_o, wcol_o
   );

   modport master (
      output clr_i, we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i, re_i, raddr_i,
      input  ready_o, rdata_o, wcol_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file. It has NUM_RD combinational read ports and two prioritised write ports with bypass.
// A clear sequencer zeroes the array after reset and on request, so the array needs no per-entry reset.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus,
   output logic         state_o
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              wcol_q, wcol_d;
   logic              commit, wr0_en, wr1_en, clr_wr;
   logic [NUM_RD*DATA_W-1:0] rdata_c;
   logic [ADDR_W-1:0] ra;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         wcol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcol_q  <= wcol_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
         end
         ST_READY: begin
            if (bus.clr_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Write enables already fold in writability, so bypass and commit can never disagree.
   always_comb begin
      clr_wr = (state_q == ST_CLEAR);
      commit = (state_q == ST_READY) && !bus.clr_i;
      wr0_en = commit && bus.we0_i && ((ZERO_REG == 0) || (bus.waddr0_i != '0));
      wr1_en = commit && bus.we1_i && ((ZERO_REG == 0) || (bus.waddr1_i != '0));
      wcol_d = wr0_en && wr1_en && (bus.waddr0_i == bus.waddr1_i);
   end

   assign bus.ready_o = (state_q == ST_READY);
   assign bus.wcol_o  = wcol_q;
   assign state_o     = state_q;

   // Port 1 is written second, so it overrides port 0 on an address clash.
   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr0_en) mem[bus.waddr0_i] <= bus.wdata0_i;
         if (wr1_en) mem[bus.waddr1_i] <= bus.wdata1_i;
      end
   end

   always_comb begin
      rdata_c = '0;
      ra      = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = bus.raddr_i[k*ADDR_W +: ADDR_W];
         if (bus.ready_o && bus.re_i[k] && !((ZERO_REG != 0) && (ra == '0))) begin
            if (wr1_en && (bus.waddr1_i == ra))      rdata_c[k*DATA_W +: DATA_W] = bus.wdata1_i;
            else if (wr0_en && (bus.waddr0_i == ra)) rdata_c[k*DATA_W +: DATA_W] = bus.wdata0_i;
            else                                     rdata_c[k*DATA_W +: DATA_W] = mem[ra];
         end
      end
   end

   assign bus.rdata_o = rdata_c;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the OpenMIPS decode stage, the next generation of the current two-read/one-write register file. It provides NUM_RD combinational read ports and two prioritised write ports, with same-cycle write-to-read bypass from both write ports. A clear sequencer zeroes every entry after reset and on demand, so the array can map onto RAM without per-entry reset. It sits between the ID stage (read side) and the WB stage (write side, two retiring results per cycle).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and never written

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- clr_i  in  1  request a full clear (sampled only in READY)
- ready_o  out  1  1 when the array is valid and writes are accepted
- we0_i  in  1  write enable, port 0
- waddr0_i  in  ADDR_W  write address, port 0
- wdata0_i  in  DATA_W  write data, port 0
- we1_i  in  1  write enable, port 1 (higher priority)
- waddr1_i  in  ADDR_W  write address, port 1
- wdata1_i  in  DATA_W  write data, port 1
- re_i  in  NUM_RD  read enable per port, bit k = port k
- raddr_i  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rdata_o  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- wcol_o  out  1  registered pulse: both write ports hit the same writable address

## Operation
- State machine: CLEAR, READY. rst low forces CLEAR, clear counter = 0, ready_o = 0, wcol_o = 0. Array contents are not reset directly.
- CLEAR: each cycle writes zero to entry[counter], counter increments. When counter = DEPTH-1 is written, next state READY. Writes from both ports are dropped. clr_i is ignored.
- READY: if clr_i = 1, next state CLEAR, counter = 0, and writes in that cycle are dropped. Otherwise, writes commit.
- Write commit: a port writes when its we is 1, and the address is not 0 or ZERO_REG = 0. If both ports target the same address, port 1 data wins.
- wcol_o is 1 in the cycle after a committed write cycle where both ports were enabled on the same writable address. It is 0 otherwise.
- Read port k is combinational. Evaluate in priority order:
  1. ready_o = 0 -> 0
  2. re_i[k] = 0 -> 0
  3. ZERO_REG = 1 and address 0 -> 0
  4. we1_i and waddr1_i match -> wdata1_i
  5. we0_i and waddr0_i match -> wdata0_i
  6. otherwise -> entry[raddr]
- Bypass applies only when the write would commit: READY, clr_i = 0, and the address is writable.
- With ZERO_REG = 0, entry 0 behaves like any other entry.

## Timing
- Write latency: a value written at edge N is visible from the array after edge N. It is visible via bypass during the cycle before edge N.
- Read latency: 0 cycles (combinational from raddr_i, re_i, write ports and state).
- Clear duration: exactly DEPTH cycles from the first CLEAR edge. ready_o rises after the DEPTH-th clearing edge.
- After rst release, the first write is accepted DEPTH cycles later.
- clr_i is a level sampled per edge. Holding it high keeps re-entering CLEAR only from READY, so clear repeats back-to-back after each completion.
- rst asserted mid-CLEAR or mid-write restarts the sequence at counter 0 immediately (asynchronously). Partially cleared contents are irrelevant because the full clear reruns.
- No output is registered except ready_o and wcol_o.

## Test plan
- Reset/clear: DATA_W=32, ADDR_W=5. Release rst, drive we0_i=1 throughout -> ready_o low for 32 cycles then high. Every read returns 0. No writes land during CLEAR.
- Write/read: write 0xDEADBEEF to r7 via port 0, then read r7 on all ports next cycle -> 0xDEADBEEF. With re_i=0 the same read -> 0.
- Bypass: in the same cycle, we0 writes r3 = 0x11 and we1 writes r3 = 0x22, reading r3 -> 0x22. The next cycle reads 0x22 from the array and wcol_o = 1 for exactly one cycle.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 and read r0 with bypass active -> 0, and wcol_o stays 0. With ZERO_REG=0 the same sequence reads back 0xFFFFFFFF.
- Soft clear: fill r1..r31 with nonzero data, pulse clr_i with a simultaneous write to r5 -> ready_o low for 32 cycles, then all reads 0, including r5.
- Reset mid-clear: assert rst at clear cycle 10, release -> ready_o stays low a full 32 cycles after release, then all entries read 0.
